// File: rtl/div_pkg.sv
// Shared types and constants for the shift/subtract divider.
//   state_t       : controller state encoding (IDLE, LOAD, SHIFT, SUB, DONE)
//   DEFAULT_WIDTH : default operand/quotient/remainder width
package div_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    SUB   = 3'd3,
    DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/div_datapath.sv
// Datapath of the restoring divider: Q/R/B registers, WIDTH+1-bit compare and
// subtract, and the combined {R,Q} left shift.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   ld                  : load operands (Q=dividend, R=0, B=divisor)
//   zfill               : with ld, load the zero-divisor result (Q=all ones, R=dividend)
//   shft                : {R,Q} <= {R,Q} << 1
//   sub                 : conditional subtract, sets Q[0] to the quotient bit
//   dividend, divisor   : operands
//   quotient, remainder : Q and low WIDTH bits of R
module div_datapath
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ld,
  input  logic             zfill,
  input  logic             shft,
  input  logic             sub,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  logic [WIDTH:0]   r;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   diff;
  logic             ge;

  // R carries one extra bit so the partial remainder never overflows the compare.
  assign diff = r - {1'b0, b};
  assign ge   = (r >= {1'b0, b});

  // Operand and partial-result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r <= '0;
      q <= '0;
      b <= '0;
    end else if (ld) begin
      b <= divisor;
      if (zfill) begin
        q <= '1;
        r <= {1'b0, dividend};
      end else begin
        q <= dividend;
        r <= '0;
      end
    end else if (shft) begin
      {r, q} <= {r[WIDTH-1:0], q, 1'b0};
    end else if (sub) begin
      if (ge) begin
        r    <= diff;
        q[0] <= 1'b1;
      end else begin
        q[0] <= 1'b0;
      end
    end
  end

  assign quotient  = q;
  assign remainder = r[WIDTH-1:0];

endmodule

// File: rtl/shift_sub_divider.sv
// Sequential unsigned restoring divider, one quotient bit per two clocks.
// Controller FSM and iteration counter; arithmetic lives in div_datapath.
// Optional feature macro: DIV_ZERO_DETECT_EN (zero-divisor fast path + dz flag).
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   start               : begin a division (sampled in IDLE only)
//   dividend, divisor   : operands, sampled in LOAD
//   quotient, remainder : result, valid with done, held until next LOAD
//   busy                : high in LOAD/SHIFT/SUB
//   done                : one-cycle pulse in DONE
//   dz                  : divide-by-zero flag, valid with done
module shift_sub_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             dz
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_t          state;
  state_t          state_nx;
  logic [CW-1:0]   cnt;
  logic            ld;
  logic            zfill;
  logic            shft;
  logic            sub;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_nx = state;
    ld       = 1'b0;
    zfill    = 1'b0;
    shft     = 1'b0;
    sub      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) state_nx = LOAD;
      end
      LOAD: begin
        ld       = 1'b1;
        state_nx = SHIFT;
`ifdef DIV_ZERO_DETECT_EN
        if (divisor == '0) begin
          zfill    = 1'b1;
          state_nx = DONE;
        end
`endif
      end
      SHIFT: begin
        shft     = 1'b1;
        state_nx = SUB;
      end
      SUB: begin
        sub = 1'b1;
        if (cnt == CW'(1)) state_nx = DONE;
        else               state_nx = SHIFT;
      end
      DONE: begin
        state_nx = IDLE;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Remaining quotient bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      cnt <= '0;
    else if (ld)  cnt <= CW'(WIDTH);
    else if (sub) cnt <= cnt - CW'(1);
  end

  // Status flags registered from the next state so they track the state register exactly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_nx == LOAD) || (state_nx == SHIFT) || (state_nx == SUB);
      done <= (state_nx == DONE);
    end
  end

`ifdef DIV_ZERO_DETECT_EN
  // Zero-divisor flag, captured at LOAD and held until the next LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     dz <= 1'b0;
    else if (ld) dz <= zfill;
  end
`else
  assign dz = 1'b0;
`endif

  div_datapath #(
    .WIDTH (WIDTH)
  ) u_datapath (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .zfill     (zfill),
    .shft      (shft),
    .sub       (sub),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder)
  );

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider (WIDTH=4). Expected results come
// from plain integer division; latency from the 2*WIDTH+1 edge timing rule.
module tb_shift_sub_divider;

  localparam int unsigned W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         busy;
  logic         done;
  logic         dz;

  int compared   = 0;
  int mismatched = 0;

`ifdef DIV_ZERO_DETECT_EN
  localparam bit ZDET = 1'b1;
`else
  localparam bit ZDET = 1'b0;
`endif

  shift_sub_divider #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .quotient  (quotient),
    .remainder (remainder),
    .busy      (busy),
    .done      (done),
    .dz        (dz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: ordinary unsigned division; divide-by-zero yields all ones / dividend.
  function automatic void model(input int a, input int b, output int q, output int r,
                                output int lat, output int z);
    if (b == 0) begin
      q   = (1 << W) - 1;
      r   = a;
      lat = ZDET ? 1 : 2 * W + 1;
      z   = ZDET ? 1 : 0;
    end else begin
      q   = a / b;
      r   = a % b;
      lat = 2 * W + 1;
      z   = 0;
    end
  endfunction

  // Present a start pulse; returns just after edge E0 with start low, operands held.
  task automatic start_op(input int a, input int b);
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(a);
    divisor  = W'(b);
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Count cycles before done rises; bounded so a stuck DUT cannot hang the run.
  task automatic wait_done(output int cyc, output int bcnt, output bit seen);
    cyc  = 0;
    bcnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
      if (busy) bcnt++;
    end
  endtask

  task automatic run_check(input string tag, input int a, input int b);
    int q, r, lat, z, cyc, bcnt;
    bit seen;
    model(a, b, q, r, lat, z);
    start_op(a, b);
    wait_done(cyc, bcnt, seen);
    chk({tag, "_seen"}, 32'(seen), 32'd1);
    chk({tag, "_lat"}, 32'(cyc), 32'(lat));
    chk({tag, "_busy"}, 32'(bcnt), 32'(lat));
    chk({tag, "_q"}, 32'(quotient), 32'(q));
    chk({tag, "_r"}, 32'(remainder), 32'(r));
    chk({tag, "_dz"}, 32'(dz), 32'(z));
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, 32'(quotient), 32'(q));
  endtask

  initial begin
    int cyc, bcnt, a, b;
    bit seen;

    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;

    // Reset state.
    repeat (2) @(negedge clk);
    chk("rst_q", 32'(quotient), 32'd0);
    chk("rst_r", 32'(remainder), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(dz), 32'd0);
    rst = 1'b0;

    // Directed cases.
    run_check("d13_4", 13, 4);
    run_check("d15_1", 15, 1);
    run_check("d3_7", 3, 7);
    run_check("d0_5", 0, 5);
    run_check("d9_0", 9, 0);
    run_check("d6_2", 6, 2);

    // Second start mid-operation is ignored.
    start_op(13, 4);
    repeat (3) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = W'(14);
    divisor  = W'(3);
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc, bcnt, seen);
    chk("ign_seen", 32'(seen), 32'd1);
    chk("ign_lat", 32'(cyc), 32'd5);
    chk("ign_q", 32'(quotient), 32'd3);
    chk("ign_r", 32'(remainder), 32'd1);

    // Asynchronous reset during the second SUB.
    start_op(13, 4);
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_q", 32'(quotient), 32'd0);
    chk("arst_r", 32'(remainder), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_check("d12_5", 12, 5);

    // Start held high: back-to-back operations every 2*W+3 cycles.
    @(negedge clk);
    start    = 1'b1;
    dividend = W'(10);
    divisor  = W'(3);
    @(posedge clk);
    wait_done(cyc, bcnt, seen);
    chk("hold0_lat", 32'(cyc), 32'(2 * W + 1));
    chk("hold0_q", 32'(quotient), 32'd3);
    chk("hold0_r", 32'(remainder), 32'd1);
    for (int i = 0; i < 2; i++) begin
      wait_done(cyc, bcnt, seen);
      chk("holdn_period", 32'(cyc + 1), 32'(2 * W + 3));
      chk("holdn_q", 32'(quotient), 32'd3);
      chk("holdn_r", 32'(remainder), 32'd1);
    end
    start = 1'b0;
    repeat (3) @(negedge clk);

    // Randomized operands against the reference model.
    for (int i = 0; i < 12; i++) begin
      a = int'($urandom_range(0, (1 << W) - 1));
      b = int'($urandom_range(0, (1 << W) - 1));
      run_check("rnd", a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/shift_sub_divider.md
# shift_sub_divider

Sequential unsigned restoring divider: the inverse of the team's shift-add multiplier. It accepts a dividend and divisor on a start pulse and iterates one quotient bit per two clocks. It returns quotient and remainder with a one-cycle done pulse. It sits beside the multiplier in the arithmetic lab datapath and uses the same Moore-style controller/datapath split.

## Interface
- WIDTH, default 4, operand/quotient/remainder width in bits (legal 2..16)
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- start  input  1  begin a division; sampled only in IDLE
- dividend  input  WIDTH  unsigned dividend; sampled in LOAD
- divisor  input  WIDTH  unsigned divisor; sampled in LOAD
- quotient  output  WIDTH  registered quotient, valid while done=1 and held until next LOAD
- remainder  output  WIDTH  registered remainder, same validity as quotient
- busy  output  1  high in LOAD, SHIFT, SUB
- done  output  1  one-cycle pulse in DONE state
- dz  output  1  divide-by-zero flag, valid with done (see Configuration)

## Operation
- States: IDLE, LOAD, SHIFT, SUB, DONE. Binary encoded, Moore outputs decoded from the state register only.
- IDLE: start=1 -> LOAD, else stay.
- LOAD:
  - Q <= dividend, B <= divisor, R <= 0 (WIDTH+1 bits), cnt <= WIDTH.
  - Next state is SHIFT. With the macro and divisor==0, next state is DONE instead.
- SHIFT: {R,Q} <= {R,Q} << 1; -> SUB.
- SUB:
  - If R >= {1'b0,B}: R <= R - B and Q[0] <= 1. Else: R unchanged and Q[0] <= 0.
  - cnt <= cnt - 1.
  - -> DONE when cnt == 1, else -> SHIFT.
- DONE: done=1; -> IDLE unconditionally.
- quotient = Q; remainder = R[WIDTH-1:0]. The subtractor is WIDTH+1 bits wide, so there is no overflow.
- start while busy or in DONE is ignored; operands are not re-sampled.
- start held high continuously: a new operation begins at each IDLE visit.
- Reset values: state IDLE; Q, R, B, cnt = 0; quotient=0, remainder=0, busy=0, done=0, dz=0.
- rst mid-operation: immediate return to reset values (asynchronous). The in-flight result is discarded.

## Timing
- Edge E0 samples start in IDLE; state enters LOAD after E0.
- done is high for the single cycle following edge E0+2*WIDTH+1. For WIDTH=4 that is the cycle after the 10th edge counting E0.
- Minimum start-to-start spacing is 2*WIDTH+3 cycles (IDLE revisit required).
- Zero-divisor fast path (macro on): done in the cycle after E1.
- Outputs change only on clk edges or on rst assertion.

## Configuration
- Macro: DIV_ZERO_DETECT_EN.
- Defined:
  - LOAD with divisor==0 goes straight to DONE.
  - Q loads all ones, R loads the dividend, and dz=1 while done.
  - dz clears on next LOAD.
- Undefined:
  - No fast path; the full iteration runs. The algorithm naturally yields quotient=all ones and remainder=dividend.
  - dz is tied to 0.

## Structure
- Package div_pkg: state enum type (IDLE, LOAD, SHIFT, SUB, DONE) and the default WIDTH constant.
- Sub-module div_datapath holds the Q/R/B registers, the subtractor/compare, and the shift logic. Its control inputs are ld, shft, sub, and zfill.
- Controller FSM and cnt live in shift_sub_divider.

## Test plan
- WIDTH=4, 13/4 -> quotient=3, remainder=1, done exactly after edge E0+9, busy high for 9 cycles before done.
- 15/1 -> q=15, r=0; 3/7 -> q=0, r=3; 0/5 -> q=0, r=0.
- 9/0:
  - With DIV_ZERO_DETECT_EN: done after E1, q=15, r=9, dz=1.
  - Without: done after E0+9, q=15, r=9, dz=0.
- Start 13/4, then pulse start with 14/3 at cycle 4 -> second request ignored, result q=3, r=1.
- Assert rst during the second SUB -> busy, done, quotient, and remainder go to 0 asynchronously. Then 12/5 after release -> q=2, r=2.
- start held high, operands 10/3 -> done pulses every 11 cycles, each q=3, r=1.
